// File: rtl/t01_ai_placement_scorer.sv
// ---------------------------------------------------------------------------
// t01_ai_placement_scorer
//
// Consumer end of the AI placement interface. On request it walks the
// candidate boards published by the placement engine one at a time. For each
// board it scans the rows top to bottom and gathers the column heights, holes
// and full lines. It turns those into a weighted heuristic score and keeps
// the best candidate's rotation and x position for the AI move controller.
//
// Board format: bit row*10+col, row 0 = top, row 19 = bottom.
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   start_eval        request an evaluation (also held high to hold DONE)
//   placement_ready   engine outputs valid
//   valid_placements  candidate count N (clamped to MAX_CAND)
//   next_boards       candidate i at [i*200 +: 200]
//   rotations         candidate i at [i*2 +: 2]
//   x_positions       candidate i at [i*4 +: 4]
//   eval_done         result valid (level, held until start_eval drops)
//   no_valid          N was 0
//   best_index/best_rotation/best_x/best_score  winning candidate
// ---------------------------------------------------------------------------
module t01_ai_placement_scorer #(
  parameter logic [3:0] W_LINES  = 4'd8,
  parameter logic [3:0] W_HOLES  = 4'd4,
  parameter logic [3:0] W_HEIGHT = 4'd1,
  parameter logic [3:0] W_BUMP   = 4'd1,
  parameter int         MAX_CAND = 40
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start_eval,
  input  logic                      placement_ready,
  input  logic [5:0]                valid_placements,
  input  logic [MAX_CAND*200-1:0]   next_boards,
  input  logic [MAX_CAND*2-1:0]     rotations,
  input  logic [MAX_CAND*4-1:0]     x_positions,
  output logic                      eval_done,
  output logic                      no_valid,
  output logic [5:0]                best_index,
  output logic [1:0]                best_rotation,
  output logic [3:0]                best_x,
  output logic signed [15:0]        best_score
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SCAN, S_SCORE, S_COMPARE, S_DONE} state_t;

  localparam logic [5:0] MAX_N = 6'(MAX_CAND);

  state_t             state_q, state_d;
  logic [5:0]         n_q, n_d, idx_q, idx_d;
  logic [199:0]       board_q, board_d;
  logic [4:0]         row_q, row_d;
  logic [9:0]         seen_q, seen_d;
  logic [9:0][4:0]    heights_q, heights_d;
  logic [7:0]         holes_q, holes_d;
  logic [4:0]         lines_q, lines_d;
  logic signed [15:0] score_q, score_d;
  logic               best_valid_q, best_valid_d;
  logic               eval_done_q, eval_done_d;
  logic               no_valid_q, no_valid_d;
  logic [5:0]         best_index_q, best_index_d;
  logic [1:0]         best_rot_q, best_rot_d;
  logic [3:0]         best_x_q, best_x_d;
  logic signed [15:0] best_score_q, best_score_d;

  // Datapath helpers derived from the current registers.
  logic [199:0]       board_sel;
  logic [1:0]         rot_sel;
  logic [3:0]         x_sel;
  logic [9:0]         row_bits;
  logic [7:0]         agg, bump;
  logic [3:0]         new_holes;
  logic signed [15:0] score_calc;
  logic [5:0]         n_clamped;

  always_comb begin
    board_sel = '0;
    rot_sel   = '0;
    x_sel     = '0;
    for (int i = 0; i < MAX_CAND; i++) begin
      if (idx_q == 6'(i)) begin
        board_sel = next_boards[i*200 +: 200];
        rot_sel   = rotations[i*2 +: 2];
        x_sel     = x_positions[i*4 +: 4];
      end
    end

    row_bits = '0;
    for (int r = 0; r < 20; r++) begin
      if (row_q == 5'(r)) row_bits = board_q[r*10 +: 10];
    end

    // Cells below a column's top block that are empty in this row.
    new_holes = '0;
    for (int c = 0; c < 10; c++) begin
      new_holes = new_holes + {3'b000, ~row_bits[c] & seen_q[c]};
    end

    agg  = '0;
    bump = '0;
    for (int c = 0; c < 10; c++) agg = agg + 8'(heights_q[c]);
    for (int c = 0; c < 9; c++) begin
      if (heights_q[c] > heights_q[c+1]) bump = bump + 8'(heights_q[c] - heights_q[c+1]);
      else                               bump = bump + 8'(heights_q[c+1] - heights_q[c]);
    end

    // Two's-complement wrap in 16 bits; no saturation.
    score_calc = 16'(W_LINES) * 16'(lines_q) - 16'(W_HOLES) * 16'(holes_q)
               - 16'(W_HEIGHT) * 16'(agg) - 16'(W_BUMP) * 16'(bump);

    n_clamped = (valid_placements > MAX_N) ? MAX_N : valid_placements;
  end

  // NOTE: every variable driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    idx_d        = idx_q;
    board_d      = board_q;
    row_d        = row_q;
    seen_d       = seen_q;
    heights_d    = heights_q;
    holes_d      = holes_q;
    lines_d      = lines_q;
    score_d      = score_q;
    best_valid_d = best_valid_q;
    eval_done_d  = eval_done_q;
    no_valid_d   = no_valid_q;
    best_index_d = best_index_q;
    best_rot_d   = best_rot_q;
    best_x_d     = best_x_q;
    best_score_d = best_score_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_eval && placement_ready) begin
          n_d          = n_clamped;
          idx_d        = '0;
          eval_done_d  = 1'b0;
          no_valid_d   = (n_clamped == '0);
          best_valid_d = 1'b0;
          best_index_d = '0;
          best_rot_d   = '0;
          best_x_d     = '0;
          best_score_d = '0;
          state_d      = (n_clamped == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        board_d   = board_sel;
        seen_d    = '0;
        heights_d = '0;
        holes_d   = '0;
        lines_d   = '0;
        row_d     = '0;
        state_d   = S_SCAN;
      end
      S_SCAN: begin
        for (int c = 0; c < 10; c++) begin
          if (row_bits[c] && !seen_q[c]) heights_d[c] = 5'd20 - row_q;
        end
        seen_d  = seen_q | row_bits;
        holes_d = holes_q + {4'b0000, new_holes};
        if (&row_bits) lines_d = lines_q + 5'd1;
        row_d = row_q + 5'd1;
        if (row_q == 5'd19) state_d = S_SCORE;
      end
      S_SCORE: begin
        score_d = score_calc;
        state_d = S_COMPARE;
      end
      S_COMPARE: begin
        // Strict '>' so that ties keep the lowest index.
        if (!best_valid_q || score_q > best_score_q) begin
          best_valid_d = 1'b1;
          best_score_d = score_q;
          best_index_d = idx_q;
          best_rot_d   = rot_sel;
          best_x_d     = x_sel;
        end
        if ({1'b0, idx_q} + 7'd1 < {1'b0, n_q}) begin
          idx_d   = idx_q + 6'd1;
          state_d = S_LOAD;
        end else begin
          eval_done_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        // eval_done must have been visible for at least one cycle before
        // leaving; this matters for the N==0 path, which enters DONE with
        // eval_done still low.
        if (eval_done_q && !start_eval) begin
          eval_done_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          eval_done_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      n_q          <= '0;
      idx_q        <= '0;
      board_q      <= '0;
      row_q        <= '0;
      seen_q       <= '0;
      heights_q    <= '0;
      holes_q      <= '0;
      lines_q      <= '0;
      score_q      <= '0;
      best_valid_q <= 1'b0;
      eval_done_q  <= 1'b0;
      no_valid_q   <= 1'b0;
      best_index_q <= '0;
      best_rot_q   <= '0;
      best_x_q     <= '0;
      best_score_q <= '0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      idx_q        <= idx_d;
      board_q      <= board_d;
      row_q        <= row_d;
      seen_q       <= seen_d;
      heights_q    <= heights_d;
      holes_q      <= holes_d;
      lines_q      <= lines_d;
      score_q      <= score_d;
      best_valid_q <= best_valid_d;
      eval_done_q  <= eval_done_d;
      no_valid_q   <= no_valid_d;
      best_index_q <= best_index_d;
      best_rot_q   <= best_rot_d;
      best_x_q     <= best_x_d;
      best_score_q <= best_score_d;
    end
  end

  assign eval_done     = eval_done_q;
  assign no_valid      = no_valid_q;
  assign best_index    = best_index_q;
  assign best_rotation = best_rot_q;
  assign best_x        = best_x_q;
  assign best_score    = best_score_q;

endmodule

// File: tb/tb_t01_ai_placement_scorer.sv
// ---------------------------------------------------------------------------
// tb_t01_ai_placement_scorer
//
// Directed bench for the placement scorer. A column-wise model of the
// heuristic supplies expected scores. A compare process checks eval_done,
// no_valid and the best_* outputs on every cycle of an armed evaluation,
// against the expected completion time. Literal checks pin the model.
// ---------------------------------------------------------------------------
module tb_t01_ai_placement_scorer;

  localparam int NC = 40;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  start_eval;
  logic                  placement_ready;
  logic [5:0]            valid_placements;
  logic [NC*200-1:0]     next_boards;
  logic [NC*2-1:0]       rotations;
  logic [NC*4-1:0]       x_positions;
  logic                  eval_done;
  logic                  no_valid;
  logic [5:0]            best_index;
  logic [1:0]            best_rotation;
  logic [3:0]            best_x;
  logic signed [15:0]    best_score;

  always #5 clk = ~clk;

  t01_ai_placement_scorer dut (
    .clk              (clk),
    .reset            (reset),
    .start_eval       (start_eval),
    .placement_ready  (placement_ready),
    .valid_placements (valid_placements),
    .next_boards      (next_boards),
    .rotations        (rotations),
    .x_positions      (x_positions),
    .eval_done        (eval_done),
    .no_valid         (no_valid),
    .best_index       (best_index),
    .best_rotation    (best_rotation),
    .best_x           (best_x),
    .best_score       (best_score)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected result of the evaluation currently armed.
  bit armed = 1'b0;
  int acc_cyc, lat;
  int exp_idx, exp_rot, exp_x, exp_score, exp_nv;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Column-wise heuristic: height = 20 - topmost filled row, holes = empty
  // cells below that top, lines = fully filled rows.
  function automatic int model_score(input logic [199:0] b);
    int h[10];
    int holes, lines, agg, bump, d;
    holes = 0; lines = 0; agg = 0; bump = 0;
    for (int c = 0; c < 10; c++) begin
      h[c] = 0;
      for (int r = 0; r < 20; r++) begin
        if (b[r*10 + c]) begin
          if (h[c] == 0) h[c] = 20 - r;
        end else if (h[c] != 0) begin
          holes++;
        end
      end
      agg += h[c];
    end
    for (int r = 0; r < 20; r++) if (&b[r*10 +: 10]) lines++;
    for (int c = 0; c < 9; c++) begin
      d = h[c] - h[c+1];
      bump += (d < 0) ? -d : d;
    end
    return 8*lines - 4*holes - agg - bump;
  endfunction

  function automatic logic [199:0] b_stack();   // col 0, rows 16..19
    logic [199:0] b = '0;
    for (int r = 16; r < 20; r++) b[r*10] = 1'b1;
    return b;
  endfunction

  function automatic logic [199:0] b_bottom();  // row 19 full
    logic [199:0] b = '0;
    b[190 +: 10] = 10'h3FF;
    return b;
  endfunction

  function automatic logic [199:0] b_hole();    // col 0 row 18 over empty row 19
    logic [199:0] b = '0;
    b[180] = 1'b1;
    return b;
  endfunction

  task automatic put(input int c, input logic [199:0] b, input int rot, input int x);
    next_boards[c*200 +: 200] = b;
    rotations[c*2 +: 2]       = 2'(rot);
    x_positions[c*4 +: 4]     = 4'(x);
  endtask

  task automatic compute_expected(input int n_raw);
    int n, s;
    n = (n_raw > NC) ? NC : n_raw;
    exp_idx = 0; exp_rot = 0; exp_x = 0; exp_score = 0;
    exp_nv  = (n == 0);
    lat     = (n == 0) ? 1 : 23 * n;
    for (int i = 0; i < n; i++) begin
      s = model_score(next_boards[i*200 +: 200]);
      if (i == 0 || s > exp_score) begin
        exp_score = s;
        exp_idx   = i;
        exp_rot   = int'(rotations[i*2 +: 2]);
        exp_x     = int'(x_positions[i*4 +: 4]);
      end
    end
  endtask

  // Drive a request on the next edge and arm the compare process.
  task automatic launch(input int n_raw);
    compute_expected(n_raw);
    @(negedge clk);
    valid_placements = 6'(n_raw);
    placement_ready  = 1'b1;
    start_eval       = 1'b1;
    acc_cyc          = cyc + 1;
    armed            = 1'b1;
  endtask

  task automatic run_eval(input int n_raw);
    int waited;
    launch(n_raw);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!eval_done && waited < lat + 10);
    check("eval_done_timeout", int'(eval_done), 1);
    @(negedge clk);              // one more held cycle under the compare process
    armed      = 1'b0;
    start_eval = 1'b0;
    @(negedge clk);
    check("eval_done_cleared", int'(eval_done), 0);
    check("idle_hold_index", int'(best_index), exp_idx);
    check("idle_hold_score", int'(best_score), exp_score);
  endtask

  always @(negedge clk) begin : compare
    bit d;
    if (armed && cyc >= acc_cyc) begin
      d = (cyc >= acc_cyc + lat);
      check("eval_done", int'(eval_done), int'(d));
      check("no_valid", int'(no_valid), exp_nv);
      if (d) begin
        check("best_index", int'(best_index), exp_idx);
        check("best_rotation", int'(best_rotation), exp_rot);
        check("best_x", int'(best_x), exp_x);
        check("best_score", int'(best_score), exp_score);
      end
    end
  end

  initial begin
    reset            = 1'b1;
    start_eval       = 1'b0;
    placement_ready  = 1'b0;
    valid_placements = '0;
    next_boards      = '0;
    rotations        = '0;
    x_positions      = '0;

    // Pin the model with hand-computed scores.
    check("model_stack", model_score(b_stack()), -8);
    check("model_bottom", model_score(b_bottom()), -2);
    check("model_hole", model_score(b_hole()), -8);
    check("model_empty", model_score('0), 0);

    repeat (3) @(negedge clk);
    check("rst_eval_done", int'(eval_done), 0);
    check("rst_no_valid", int'(no_valid), 0);
    check("rst_best_index", int'(best_index), 0);
    check("rst_best_score", int'(best_score), 0);
    reset = 1'b0;
    @(negedge clk);

    // 1: stack (-8) vs full bottom row (-2).
    put(0, b_stack(), 0, 0);
    put(1, b_bottom(), 1, 3);
    run_eval(2);
    check("t1_best_index", int'(best_index), 1);
    check("t1_best_rotation", int'(best_rotation), 1);
    check("t1_best_x", int'(best_x), 3);
    check("t1_best_score", int'(best_score), -2);

    // 2: single candidate with one hole.
    next_boards = '0; rotations = '0; x_positions = '0;
    put(0, b_hole(), 2, 6);
    run_eval(1);
    check("t2_best_score", int'(best_score), -8);
    check("t2_no_valid", int'(no_valid), 0);

    // 3: identical boards, tie keeps the lowest index.
    put(0, b_bottom(), 1, 3);
    put(1, b_bottom(), 2, 7);
    run_eval(2);
    check("t3_best_index", int'(best_index), 0);

    // 4: no candidates.
    run_eval(0);
    check("t4_no_valid", int'(no_valid), 1);
    check("t4_best_x", int'(best_x), 0);

    // 5: start without placement_ready is ignored.
    @(negedge clk);
    start_eval       = 1'b1;
    placement_ready  = 1'b0;
    valid_placements = 6'd3;
    repeat (5) begin
      @(negedge clk);
      check("t5_not_ready", int'(eval_done), 0);
    end
    start_eval = 1'b0;

    // 5b: reset while scanning candidate 1 of a 3-candidate run.
    next_boards = '0; rotations = '0; x_positions = '0;
    put(0, b_bottom(), 2, 5);
    put(1, b_stack(), 1, 1);
    put(2, '0, 3, 9);
    launch(3);
    repeat (33) @(negedge clk);
    armed = 1'b0;
    check("t5_partial_best_x", int'(best_x), 5);
    #2 reset = 1'b1;
    #1;
    check("t5_rst_best_x", int'(best_x), 0);
    check("t5_rst_best_rot", int'(best_rotation), 0);
    check("t5_rst_best_score", int'(best_score), 0);
    check("t5_rst_eval_done", int'(eval_done), 0);
    @(negedge clk);
    start_eval = 1'b0;
    reset      = 1'b0;
    @(negedge clk);
    check("t5_idle_after_rst", int'(eval_done), 0);
    run_eval(3);
    check("t5_rerun_index", int'(best_index), 2);

    // 6: clamp 50 -> 40. Slots 0..38 carry the stack (-8), slot 39 the
    // full bottom row (-2), so the last slot must win.
    next_boards = '0; rotations = '0; x_positions = '0;
    for (int i = 0; i < NC - 1; i++) put(i, b_stack(), i % 4, i % 10);
    put(NC - 1, b_bottom(), 3, 12);
    run_eval(50);
    check("t6_best_index", int'(best_index), 39);
    check("t6_best_score", int'(best_score), -2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
